pixel_write_scheduler: RTL and testbench
========================================

# pixel_write_scheduler

Sole owner of the LT24Display pixel-write port. It arbitrates between two sources: a built-in full-screen fill sequencer and a single external draw-request port fed by the etch cursor logic. Each accepted request becomes exactly one handshaked pixel write. The block sits between the user drawing logic and the LT24Display pixel interface (pixelRawMode tied low).

## Interface
Parameters:
- WIDTH, 240, display width in pixels; x range 0..WIDTH-1.
- HEIGHT, 320, display height in pixels; y range 0..HEIGHT-1.

Ports:
- clock  in  1  system clock (50 MHz).
- reset_n  in  1  reset; **synchronous, active-low**. All state is cleared on the rising clock edge while low.
- clearStart  in  1  single-cycle pulse; request a full-screen fill.
- clearColour  in  16  RGB565 fill colour; sampled in the cycle clearStart is accepted.
- clearBusy  out  1  high from clearStart acceptance until the last fill write completes.
- clearDone  out  1  one-cycle pulse after the last fill write.
- reqValid  in  1  draw request valid.
- reqReady  out  1  draw request can be accepted this cycle.
- reqX  in  8  draw x coordinate.
- reqY  in  9  draw y coordinate.
- reqColour  in  16  RGB565 draw colour.
- reqDropped  out  1  one-cycle pulse when a request is discarded (macro only; otherwise tied 0).
- xAddr  out  8  to LT24Display.
- yAddr  out  9  to LT24Display.
- pixelData  out  16  to LT24Display.
- pixelWrite  out  1  to LT24Display.
- pixelReady  in  1  from LT24Display; a write transfers on any cycle where pixelWrite && pixelReady.

## Operation
States: IDLE, FILL, DRAW.
- Reset values:
  - state = IDLE.
  - xAddr = 0, yAddr = 0, pixelData = 0, pixelWrite = 0.
  - clearBusy = 0, clearDone = 0, reqDropped = 0.
  - Pending-clear flag = 0; fill counters = 0.
- reqReady is combinational: state == IDLE && !clearPending && !clearStart.
- Clear capture:
  - clearStart while clearBusy = 0: set clearPending and clearBusy, latch clearColour.
  - clearStart while clearBusy = 1: ignored. No restart, no re-latch of colour.
- IDLE:
  - If clearPending: go to FILL; load xAddr = 0, yAddr = 0, pixelData = latched colour, pixelWrite = 1; clear clearPending.
  - Else if reqValid && reqReady: latch reqX/reqY/reqColour into xAddr/yAddr/pixelData; pixelWrite = 1; go to DRAW.
  - Clear takes priority over a simultaneous draw request, because reqReady is low whenever clearStart is high.
- FILL:
  - pixelWrite stays high continuously.
  - On each transfer, advance in raster order: x increments; at x = WIDTH-1, x wraps to 0 and y increments.
  - Transfer at (WIDTH-1, HEIGHT-1): pixelWrite = 0, clearBusy = 0, clearDone pulses, go to IDLE.
  - Exactly WIDTH*HEIGHT (76800) transfers occur; every pixel is written once.
- DRAW:
  - Hold xAddr/yAddr/pixelData/pixelWrite stable until the transfer.
  - On transfer: pixelWrite = 0, go to IDLE.
  - A clearStart arriving during DRAW is latched and serviced once the draw completes.
- Counter widths match the port widths: x is 8 bits, y is 9 bits. There is no wrap beyond WIDTH-1/HEIGHT-1.
- Reset mid-FILL or mid-DRAW: on the next edge, pixelWrite = 0 and everything returns to reset values. The fill is abandoned and clearDone does not pulse.

## Timing
- Draw acceptance edge N: pixelWrite = 1 at N+1. It is held until the first edge where pixelReady = 1, then drops one cycle later.
- Minimum draw cost is 2 cycles (accept, transfer). The next request can be accepted the cycle after return to IDLE.
- Fill: clearStart at edge N, FILL entered at N+1 (from IDLE).
- Fill throughput is one pixel per pixelReady-high cycle, with no bubbles between fill pixels.
- pixelWrite never deasserts before a transfer.
- Address and data never change while pixelWrite = 1 && pixelReady = 0.

## Configuration
- PIXEL_SCHED_BOUNDS_CHECK_EN defined:
  - A request with reqX >= WIDTH or reqY >= HEIGHT is still accepted (handshake completes).
  - No write is issued; state stays IDLE; reqDropped pulses the cycle after acceptance.
- Macro undefined:
  - No range check; reqDropped is tied 0.
  - Out-of-range coordinates pass through to LT24Display unchanged.

## Structure
- Shared package lt24_pkg:
  - LT24_WIDTH = 240, LT24_HEIGHT = 320.
  - RGB565 colour constants: RED 16'hF800, GREEN 16'h07E0, BLUE 16'h001F, BLACK 16'h0000, WHITE 16'hFFFF.
  - State encoding (one-hot, 3 bits).
- One sub-module: screen_fill_counter.
  - Raster x/y counter with advance, load-zero and last-pixel flag.
  - Parameterised by WIDTH/HEIGHT.

## Test plan
- **Reset:** hold reset_n low 3 cycles during a draw with pixelReady = 0 -> pixelWrite = 0, clearBusy = 0 the edge after; reqReady = 1 after release.
- **Single draw:** reqValid with (10,10,16'hF800), pixelReady stalled low 5 cycles -> outputs stable and pixelWrite high throughout; exactly one transfer; then reqReady returns high.
- **Full fill:** clearStart with 16'h0000, pixelReady = 1 constantly -> 76800 transfers in raster order; last at (239,319); clearDone pulses once; clearBusy low after.
- **Simultaneous events:** clearStart and reqValid in the same IDLE cycle -> fill runs first, request stalls (reqReady = 0), then it is accepted after clearDone.
- **Clear during draw, retrigger during fill:**
  - clearStart during DRAW -> draw completes, then the fill starts.
  - Second clearStart mid-fill -> ignored; total transfers remain 76800.
- **Bounds (macro on):** request (240,5) -> handshake completes, no pixelWrite, reqDropped pulses; request (239,319) -> written normally.

Source files
------------

// File: rtl/pixel_write_scheduler_pkg.sv
// Shared LT24 display constants, colours and the scheduler state encoding.
// Also carries the coordinate range check used when PIXEL_SCHED_BOUNDS_CHECK_EN is defined.
package pixel_write_scheduler_pkg;

  localparam int LT24_WIDTH  = 240;
  localparam int LT24_HEIGHT = 320;

  localparam int X_W      = 8;
  localparam int Y_W      = 9;
  localparam int COLOUR_W = 16;

  localparam logic [COLOUR_W-1:0] RGB_RED   = 16'hF800;
  localparam logic [COLOUR_W-1:0] RGB_GREEN = 16'h07E0;
  localparam logic [COLOUR_W-1:0] RGB_BLUE  = 16'h001F;
  localparam logic [COLOUR_W-1:0] RGB_BLACK = 16'h0000;
  localparam logic [COLOUR_W-1:0] RGB_WHITE = 16'hFFFF;

  // One-hot so each state bit can be probed directly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_FILL = 3'b010,
    ST_DRAW = 3'b100
  } state_t;

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int width, input int height);
    return (int'(x) < width) && (int'(y) < height);
  endfunction

endpackage

// File: rtl/pixel_write_scheduler_if.sv
// Clear control, draw-request and LT24 pixel-port signals of the scheduler.
// Handshakes: a draw request moves when reqValid && reqReady; a pixel moves when pixelWrite && pixelReady.
interface pixel_write_scheduler_if;
  import pixel_write_scheduler_pkg::*;

  logic                clearStart;
  logic [COLOUR_W-1:0] clearColour;
  logic                clearBusy;
  logic                clearDone;

  logic                reqValid;
  logic                reqReady;
  logic [X_W-1:0]      reqX;
  logic [Y_W-1:0]      reqY;
  logic [COLOUR_W-1:0] reqColour;
  logic                reqDropped;

  logic [X_W-1:0]      xAddr;
  logic [Y_W-1:0]      yAddr;
  logic [COLOUR_W-1:0] pixelData;
  logic                pixelWrite;
  logic                pixelReady;

  modport slave (
    input  clearStart, clearColour, reqValid, reqX, reqY, reqColour, pixelReady,
    output clearBusy, clearDone, reqReady, reqDropped, xAddr, yAddr, pixelData, pixelWrite
  );

  modport master (
    output clearStart, clearColour, reqValid, reqX, reqY, reqColour, pixelReady,
    input  clearBusy, clearDone, reqReady, reqDropped, xAddr, yAddr, pixelData, pixelWrite
  );

endinterface

// File: rtl/pixel_write_scheduler_screen_fill_counter.sv
// Raster-order x/y counter for the full-screen fill: x runs fastest, y steps on each x wrap.
// last flags the bottom-right pixel; advancing from it returns both counters to zero.
module pixel_write_scheduler_screen_fill_counter
  import pixel_write_scheduler_pkg::*;
#(
  parameter int WIDTH  = LT24_WIDTH,
  parameter int HEIGHT = LT24_HEIGHT
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           load_zero,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  logic x_at_end;
  logic y_at_end;

  assign x_at_end = (x == X_LAST);
  assign y_at_end = (y == Y_LAST);
  assign last     = x_at_end && y_at_end;

  always_ff @(posedge clock) begin
    if (!reset_n || load_zero) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_at_end) begin
        x <= '0;
        y <= y_at_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Sole owner of the LT24 pixel-write port: arbitrates a full-screen fill against single draw requests.
// Optional feature macro: PIXEL_SCHED_BOUNDS_CHECK_EN (discard draws outside the screen, pulse reqDropped).
module pixel_write_scheduler
  import pixel_write_scheduler_pkg::*;
#(
  parameter int WIDTH  = LT24_WIDTH,
  parameter int HEIGHT = LT24_HEIGHT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  pixel_write_scheduler_if.slave  bus,
  output state_t                  dbg_state
);

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dropped_q, dropped_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                write_q, write_d;

  logic                req_ready;
  logic                req_oob;
  logic                transfer;
  logic                fill_zero;
  logic                fill_advance;
  logic [X_W-1:0]      fill_x;
  logic [Y_W-1:0]      fill_y;
  logic                fill_last;

`ifdef PIXEL_SCHED_BOUNDS_CHECK_EN
  assign req_oob = !in_bounds(bus.reqX, bus.reqY, WIDTH, HEIGHT);
`else
  assign req_oob = 1'b0;
`endif

  // A clearStart in the same cycle blocks the draw so the clear always wins.
  assign req_ready = (state_q == ST_IDLE) && !pending_q && !bus.clearStart;
  assign transfer  = write_q && bus.pixelReady;

  pixel_write_scheduler_screen_fill_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_fill_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_zero (fill_zero),
    .advance   (fill_advance),
    .x         (fill_x),
    .y         (fill_y),
    .last      (fill_last)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    colour_d     = colour_q;
    done_d       = 1'b0;
    dropped_d    = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    data_d       = data_q;
    write_d      = write_q;
    fill_zero    = 1'b0;
    fill_advance = 1'b0;

    // A clear is captured in any state, but only once per fill.
    if (bus.clearStart && !busy_q) begin
      pending_d = 1'b1;
      busy_d    = 1'b1;
      colour_d  = bus.clearColour;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_FILL;
          pending_d = 1'b0;
          data_d    = colour_q;
          write_d   = 1'b1;
          fill_zero = 1'b1;
        end else if (bus.reqValid && req_ready) begin
          if (req_oob) begin
            dropped_d = 1'b1;
          end else begin
            x_d     = bus.reqX;
            y_d     = bus.reqY;
            data_d  = bus.reqColour;
            write_d = 1'b1;
            state_d = ST_DRAW;
          end
        end
      end
      ST_FILL: begin
        if (transfer) begin
          fill_advance = 1'b1;
          if (fill_last) begin
            write_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAW: begin
        if (transfer) begin
          write_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      colour_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      colour_q  <= colour_d;
      x_q       <= x_d;
      y_q       <= y_d;
      data_q    <= data_d;
      write_q   <= write_d;
    end
  end

  // During a fill the raster counter drives the address directly.
  assign bus.xAddr      = (state_q == ST_FILL) ? fill_x : x_q;
  assign bus.yAddr      = (state_q == ST_FILL) ? fill_y : y_q;
  assign bus.pixelData  = data_q;
  assign bus.pixelWrite = write_q;
  assign bus.reqReady   = req_ready;
  assign bus.clearBusy  = busy_q;
  assign bus.clearDone  = done_q;
  assign bus.reqDropped = dropped_q;
  assign dbg_state      = state_q;

  property p_hold_until_transfer;
    @(posedge clock) disable iff (!reset_n)
      (bus.pixelWrite && !bus.pixelReady) |=>
        (bus.pixelWrite && $stable({bus.xAddr, bus.yAddr, bus.pixelData}));
  endproperty
  a_hold_until_transfer: assert property (p_hold_until_transfer);

  property p_done_ends_busy;
    @(posedge clock) disable iff (!reset_n) bus.clearDone |-> !bus.clearBusy;
  endproperty
  a_done_ends_busy: assert property (p_done_ends_busy);

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Randomised scoreboard bench for pixel_write_scheduler on a small screen so every fill is short.
// Expected pixel writes are queued at stimulus time and popped by an independent monitor.
module tb_pixel_write_scheduler;
  import pixel_write_scheduler_pkg::*;

  localparam int W  = 13;
  localparam int H  = 11;
  localparam int EW = 34;  // {last_of_fill, x[7:0], y[8:0], colour[15:0]}

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0: stall, 1: always ready, 2: random

  logic [EW-1:0] exp_q[$];
  logic          done_expect = 1'b0;
  logic          prev_stall = 1'b0;
  logic [32:0]   prev_vec = '0;

  pixel_write_scheduler_if bus();

  pixel_write_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [EW-1:0] pack(input bit last, input int x, input int y,
                                         input logic [15:0] c);
    return {last, 8'(x), 9'(y), c};
  endfunction

  function automatic void push_fill(input logic [15:0] c);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back(pack((x == W - 1) && (y == H - 1), x, y, c));
  endfunction

  // ---------------- pixelReady driver ----------------
  initial begin
    bus.pixelReady = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.pixelReady = 1'b0;
        1:       bus.pixelReady = 1'b1;
        default: bus.pixelReady = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      done_expect = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      chk("clear_done", bus.clearDone, done_expect);
      done_expect = 1'b0;
      if (bus.clearDone) done_cnt++;
      if (prev_stall) begin
        chk("stall_hold", {bus.pixelWrite, bus.xAddr, bus.yAddr, bus.pixelData},
            {1'b1, prev_vec});
      end
      if (bus.pixelWrite && bus.pixelReady) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {bus.xAddr, bus.yAddr, bus.pixelData}, 64'hDEAD_BEEF_0000_0000);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("pixel", {bus.xAddr, bus.yAddr, bus.pixelData}, e[32:0]);
          if (e[33]) done_expect = 1'b1;
        end
      end
      prev_stall = bus.pixelWrite && !bus.pixelReady;
      prev_vec   = {bus.xAddr, bus.yAddr, bus.pixelData};
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic issue_req(input int x, input int y, input logic [15:0] c, input bit push_en);
    bit oob;
    bit exp_write;
    bit exp_drop;
    bit accepted;
    oob = (x >= W) || (y >= H);
`ifdef PIXEL_SCHED_BOUNDS_CHECK_EN
    exp_write = !oob;
    exp_drop  = oob;
`else
    exp_write = 1'b1;
    exp_drop  = 1'b0;
`endif
    bus.reqValid  = 1'b1;
    bus.reqX      = 8'(x);
    bus.reqY      = 9'(y);
    bus.reqColour = c;
    if (push_en && exp_write) exp_q.push_back(pack(1'b0, x, y, c));
    accepted = 1'b0;
    for (int i = 0; i < 5000 && !accepted; i++) begin
      @(negedge clock);
      if (bus.reqReady) accepted = 1'b1;
    end
    chk("req_accept_timeout", accepted, 1'b1);
    @(posedge clock);
    #1;
    bus.reqValid  = 1'b0;
    bus.reqX      = 8'($urandom);
    bus.reqY      = 9'($urandom);
    bus.reqColour = 16'($urandom);
    @(negedge clock);
    if (accepted) chk("req_dropped", bus.reqDropped, exp_drop);
    @(posedge clock);
    #1;
  endtask

  task automatic issue_clear(input logic [15:0] c, input bit accept);
    bus.clearStart  = 1'b1;
    bus.clearColour = c;
    if (accept) push_fill(c);
    @(posedge clock);
    #1;
    bus.clearStart  = 1'b0;
    bus.clearColour = 16'($urandom);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clock);
    chk({name, "_drain"}, exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic set_ready(input int mode);
    @(negedge clock);
    ready_mode = mode;
    @(posedge clock);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (40000) @(posedge clock);
    n_fail++;
    $display("FAIL watchdog: cycle budget expired, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base_x;
    int base_d;
    bus.clearStart  = 1'b0;
    bus.clearColour = '0;
    bus.reqValid    = 1'b0;
    bus.reqX        = '0;
    bus.reqY        = '0;
    bus.reqColour   = '0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_pixel_write", bus.pixelWrite, 1'b0);
    chk("rst_addr_data", {bus.xAddr, bus.yAddr, bus.pixelData}, 33'd0);
    chk("rst_clear_flags", {bus.clearBusy, bus.clearDone, bus.reqDropped}, 3'b000);
    chk("rst_state", dbg_state, 3'b001);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", bus.reqReady, 1'b1);
    @(posedge clock);
    #1;

    // Reset held 3 cycles during a stalled draw
    ready_mode = 0;
    issue_req(4, 6, 16'h1234, 1'b0);
    chk("draw_pending_write", bus.pixelWrite, 1'b1);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    chk("rst_mid_draw_write", bus.pixelWrite, 1'b0);
    chk("rst_mid_draw_busy", bus.clearBusy, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_release_ready", bus.reqReady, 1'b1);
    @(posedge clock);
    #1;

    // Single draw stalled 5 cycles
    base_x = xfer_cnt;
    issue_req(10, 10, RGB_RED, 1'b1);
    repeat (5) begin
      @(negedge clock);
      chk("draw_stall_write", bus.pixelWrite, 1'b1);
    end
    set_ready(1);
    wait_drain("single_draw");
    chk("single_draw_count", xfer_cnt - base_x, 1);
    @(negedge clock);
    chk("single_draw_ready", bus.reqReady, 1'b1);
    @(posedge clock);
    #1;

    // Full fill with black, pixelReady always high
    base_x = xfer_cnt;
    base_d = done_cnt;
    issue_clear(RGB_BLACK, 1'b1);
    chk("fill_busy", bus.clearBusy, 1'b1);
    wait_drain("fill_black");
    chk("fill_count", xfer_cnt - base_x, W * H);
    chk("fill_done_count", done_cnt - base_d, 1);
    chk("fill_busy_after", bus.clearBusy, 1'b0);

    // Clear and draw in the same IDLE cycle: fill first
    set_ready(2);
    base_d = done_cnt;
    bus.clearStart  = 1'b1;
    bus.clearColour = RGB_BLUE;
    bus.reqValid    = 1'b1;
    bus.reqX        = 8'd3;
    bus.reqY        = 9'd4;
    bus.reqColour   = RGB_GREEN;
    push_fill(RGB_BLUE);
    exp_q.push_back(pack(1'b0, 3, 4, RGB_GREEN));
    @(negedge clock);
    chk("simul_req_ready", bus.reqReady, 1'b0);
    @(posedge clock);
    #1;
    bus.clearStart = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("simul_mid_fill", {bus.reqReady, bus.clearBusy, dbg_state}, {2'b01, 3'b010});
    @(posedge clock);
    #1;
    issue_req(3, 4, RGB_GREEN, 1'b0);
    wait_drain("simultaneous");
    chk("simul_done_count", done_cnt - base_d, 1);

    // Clear arriving during a stalled draw
    set_ready(0);
    base_d = done_cnt;
    issue_req(W - 1, 0, RGB_WHITE, 1'b1);
    issue_clear(16'h5AA5, 1'b1);
    @(negedge clock);
    chk("clear_in_draw", {bus.clearBusy, bus.pixelWrite, dbg_state}, {2'b11, 3'b100});
    ready_mode = 2;
    @(posedge clock);
    #1;
    wait_drain("clear_during_draw");
    chk("cdd_done_count", done_cnt - base_d, 1);

    // Retrigger mid-fill is ignored
    base_x = xfer_cnt;
    base_d = done_cnt;
    issue_clear(RGB_RED, 1'b1);
    repeat (25) @(posedge clock);
    #1;
    issue_clear(RGB_WHITE, 1'b0);
    wait_drain("retrigger");
    repeat (10) @(posedge clock);
    #1;
    chk("retrigger_count", xfer_cnt - base_x, W * H);
    chk("retrigger_done_count", done_cnt - base_d, 1);

    // Reset mid-fill abandons it; the next fill restarts at (0,0)
    set_ready(1);
    base_d = done_cnt;
    issue_clear(RGB_BLUE, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    chk("rst_mid_fill", {bus.clearBusy, bus.pixelWrite, dbg_state}, {2'b00, 3'b001});
    reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_mid_fill_no_done", done_cnt - base_d, 0);
    issue_clear(RGB_GREEN, 1'b1);
    wait_drain("fill_after_reset");

    // Random and corner draws under random back-pressure
    set_ready(2);
    issue_req(0, 0, 16'($urandom), 1'b1);
    issue_req(W - 1, H - 1, 16'($urandom), 1'b1);
    issue_req(0, H - 1, 16'($urandom), 1'b1);
    for (int i = 0; i < 24; i++)
      issue_req($urandom_range(0, W - 1), $urandom_range(0, H - 1), 16'($urandom), 1'b1);
    issue_req(200, 5, RGB_RED, 1'b1);
    issue_req(5, 300, RGB_BLUE, 1'b1);
    issue_req(255, 511, RGB_WHITE, 1'b1);
    issue_req(W - 1, H - 1, RGB_GREEN, 1'b1);
    wait_drain("random_draws");

    repeat (5) @(posedge clock);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
